stream_check_sink: RTL and testbench

- Receiving end of the valid/ready `intN` stream interface used by generated blocks and their benches.
- Consumes an output stream under a programmable backpressure pattern.
- Checks every accepted beat against an expected arithmetic progression, and accumulates a beat count and checksum.
- Reports pass/fail and the first mismatch, so stream benches can finish with a self-checking result instead of a TODO print.

---
 rtl/stream_check_sink.sv | 64 ++++++
 tb/tb_stream_check_sink.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/stream_check_sink.sv
// stream_check_sink: backpressured stream sink checking beats against an arithmetic progression.
module stream_check_sink #(
  parameter int N = 8,
  parameter logic [N-1:0] EXP_START = '0,
  parameter logic [N-1:0] EXP_STEP = N'(1),
  parameter int MAX_BEATS = 16,
  parameter int CNT_W = 16,
  parameter logic [7:0] READY_PAT = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic [N-1:0]     in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [CNT_W-1:0] beat_count,
  output logic [N-1:0]     checksum,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] bad_index,
  output logic [N-1:0]     bad_value
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] pat;
  logic [N-1:0] exp_val;
  logic xfer, last;
  assign in_ready = (state == RUN) & enable & pat[0];
  assign xfer = in_valid & in_ready;
  assign last = xfer & (beat_count == CNT_W'(MAX_BEATS - 1));
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    state_nx = clear ? IDLE : (state == IDLE && enable) ? RUN : last ? DONE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      pat <= READY_PAT;
      exp_val <= EXP_START;
      beat_count <= '0;
      checksum <= '0;
      error <= 1'b0;
      bad_index <= '0;
      bad_value <= '0;
    end else begin
      // the mask advances every enabled RUN cycle, independent of transfers
      if (state == RUN && enable) pat <= {pat[0], pat[7:1]};
      if (xfer) begin
        beat_count <= beat_count + CNT_W'(1);
        checksum <= checksum + in;
        exp_val <= exp_val + EXP_STEP;
        if (in != exp_val && !error) begin
          error <= 1'b1;
          bad_index <= beat_count;
          bad_value <= in;
        end
      end
    end
  end
endmodule

// File: tb/tb_stream_check_sink.sv
// tb_stream_check_sink: randomized scenarios against a queue-free beat-level model of the sink.
module tb_stream_check_sink;
  logic clk = 0, rst = 1;
  logic en[3], clr[3], vld[3], rdy[3], dn[3], er[3];
  logic [7:0] din[3], cs[3], bv[3];
  logic [15:0] bc[3], bi[3];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  stream_check_sink #(.READY_PAT(8'hFF)) u0 (.clk(clk), .rst(rst), .enable(en[0]), .clear(clr[0]),
    .in(din[0]), .in_valid(vld[0]), .in_ready(rdy[0]), .beat_count(bc[0]), .checksum(cs[0]),
    .done(dn[0]), .error(er[0]), .bad_index(bi[0]), .bad_value(bv[0]));
  stream_check_sink #(.READY_PAT(8'b0101_0101)) u1 (.clk(clk), .rst(rst), .enable(en[1]), .clear(clr[1]),
    .in(din[1]), .in_valid(vld[1]), .in_ready(rdy[1]), .beat_count(bc[1]), .checksum(cs[1]),
    .done(dn[1]), .error(er[1]), .bad_index(bi[1]), .bad_value(bv[1]));
  stream_check_sink #(.EXP_START(8'hFE), .MAX_BEATS(4)) u2 (.clk(clk), .rst(rst), .enable(en[2]), .clear(clr[2]),
    .in(din[2]), .in_valid(vld[2]), .in_ready(rdy[2]), .beat_count(bc[2]), .checksum(cs[2]),
    .done(dn[2]), .error(er[2]), .bad_index(bi[2]), .bad_value(bv[2]));

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      en[k] = 0; clr[k] = 0; vld[k] = 0; din[k] = 0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tests++; if (rdy[k] !== 1'b0) begin fails++; $display("FAIL reset_ready[%0d] got %b want 0", k, rdy[k]); end
      tests++; if (bc[k] !== 16'd0) begin fails++; $display("FAIL reset_count[%0d] got %0d want 0", k, bc[k]); end
      tests++; if (cs[k] !== 8'd0) begin fails++; $display("FAIL reset_sum[%0d] got %h want 0", k, cs[k]); end
      tests++; if ({dn[k], er[k]} !== 2'b00) begin fails++; $display("FAIL reset_flags[%0d] got %b want 00", k, {dn[k], er[k]}); end
      tests++; if ({bi[k], bv[k]} !== 24'd0) begin fails++; $display("FAIL reset_bad[%0d] got %h want 0", k, {bi[k], bv[k]}); end
    end
    rst = 0;
  endtask

  // clear asserted together with enable must win and leave the sink idle and zeroed
  task automatic do_clear(input int k);
    @(negedge clk);
    clr[k] = 1; en[k] = 1; vld[k] = 1;
    @(negedge clk);
    #1;
    tests++; if ({rdy[k], dn[k], er[k]} !== 3'b000) begin fails++; $display("FAIL clear_flags[%0d] got %b want 000", k, {rdy[k], dn[k], er[k]}); end
    tests++; if ({bc[k], cs[k], bi[k], bv[k]} !== 48'd0) begin fails++; $display("FAIL clear_regs[%0d] got %h want 0", k, {bc[k], cs[k], bi[k], bv[k]}); end
    clr[k] = 0; en[k] = 0; vld[k] = 0;
  endtask

  // c1/c2: beat indices replaced by v1/v2; rv: random valid; pause of pl cycles once pa beats are in
  task automatic run(input int k, input int c1, input logic [7:0] v1, input int c2, input logic [7:0] v2,
                     input bit rv, input int pa, input int pl, output logic [7:0] sum, output bit err, output int bidx);
    logic [7:0] st, pt, msum, mbv, d;
    int mx, cnt, rc, pc, cyc, mbi;
    bit mrun, mdone, merr, mrdy, v, e;
    st = (k == 2) ? 8'hFE : 8'h00;
    pt = (k == 1) ? 8'h55 : 8'hFF;
    mx = (k == 2) ? 4 : 16;
    cnt = 0; rc = 0; pc = 0; cyc = 0; mbi = 0; msum = 0; mbv = 0;
    mrun = 0; mdone = 0; merr = 0;
    do_clear(k);
    while (!mdone && cyc < 300) begin
      @(negedge clk);
      e = !(cnt == pa && pc < pl);
      if (!e) pc++;
      d = (cnt == c1) ? v1 : (cnt == c2) ? v2 : 8'(st + 8'(cnt));
      v = rv ? ($urandom_range(0, 1) == 1) : 1'b1;
      en[k] = e; din[k] = d; vld[k] = v;
      #1;
      mrdy = mrun && e && pt[rc % 8];
      tests++; if (rdy[k] !== mrdy) begin fails++; $display("FAIL ready[%0d] cyc %0d got %b want %b", k, cyc, rdy[k], mrdy); end
      tests++; if (bc[k] !== 16'(cnt)) begin fails++; $display("FAIL count[%0d] cyc %0d got %0d want %0d", k, cyc, bc[k], cnt); end
      tests++; if (cs[k] !== msum || er[k] !== merr || dn[k] !== 1'b0) begin
        fails++; $display("FAIL status[%0d] cyc %0d got sum %h err %b done %b want %h %b 0", k, cyc, cs[k], er[k], dn[k], msum, merr);
      end
      if (mrun && e) rc++;
      if (mrdy && v) begin
        if (!merr && d !== 8'(st + 8'(cnt))) begin merr = 1; mbi = cnt; mbv = d; end
        msum = msum + d;
        cnt++;
        if (cnt == mx) begin mrun = 0; mdone = 1; end
      end else if (!mrun && e) mrun = 1;
      cyc++;
    end
    tests++; if (!mdone) begin fails++; $display("FAIL budget[%0d] got %0d beats want %0d", k, cnt, mx); end
    repeat (2) begin
      @(negedge clk);
      vld[k] = 1; en[k] = 1;
      #1;
      tests++; if ({dn[k], rdy[k]} !== 2'b10) begin fails++; $display("FAIL done[%0d] got done %b ready %b want 1 0", k, dn[k], rdy[k]); end
      tests++; if (bc[k] !== 16'(mx) || cs[k] !== msum) begin fails++; $display("FAIL final[%0d] got %0d/%h want %0d/%h", k, bc[k], cs[k], mx, msum); end
      tests++; if (er[k] !== merr || bi[k] !== 16'(mbi) || bv[k] !== mbv) begin
        fails++; $display("FAIL bad[%0d] got %b %0d %h want %b %0d %h", k, er[k], bi[k], bv[k], merr, mbi, mbv);
      end
    end
    sum = msum; err = merr; bidx = mbi;
  endtask

  task automatic test_pass();
    logic [7:0] s; bit e; int b;
    run(0, -1, 0, -1, 0, 0, -1, 0, s, e, b);
    tests++; if (cs[0] !== 8'h78 || er[0] !== 1'b0) begin fails++; $display("FAIL pass_sum got %h err %b want 78 0", cs[0], er[0]); end
  endtask

  task automatic test_backpressure();
    logic [7:0] s; bit e; int b;
    run(1, -1, 0, -1, 0, 0, -1, 0, s, e, b);
    tests++; if (cs[1] !== 8'h78 || er[1] !== 1'b0) begin fails++; $display("FAIL bp_sum got %h err %b want 78 0", cs[1], er[1]); end
  endtask

  task automatic test_mismatch();
    logic [7:0] s; bit e; int b;
    run(0, 5, 8'h2A, -1, 0, 0, -1, 0, s, e, b);
    tests++; if ({er[0], bi[0], bv[0], cs[0]} !== {1'b1, 16'd5, 8'h2A, 8'h9D}) begin
      fails++; $display("FAIL mismatch got %b %0d %h %h want 1 5 2a 9d", er[0], bi[0], bv[0], cs[0]);
    end
    run(0, 5, 8'h2A, 9, 8'hC3, 1, -1, 0, s, e, b);
    tests++; if (bi[0] !== 16'd5) begin fails++; $display("FAIL second_mismatch got %0d want 5", bi[0]); end
    run(0, 15, 8'h00, -1, 0, 0, -1, 0, s, e, b);
    tests++; if ({er[0], bi[0]} !== {1'b1, 16'd15}) begin fails++; $display("FAIL last_beat got %b %0d want 1 15", er[0], bi[0]); end
  endtask

  task automatic test_wrap();
    logic [7:0] s; bit e; int b;
    run(2, -1, 0, -1, 0, 0, -1, 0, s, e, b);
    tests++; if (cs[2] !== 8'hFE || er[2] !== 1'b0) begin fails++; $display("FAIL wrap got %h err %b want fe 0", cs[2], er[2]); end
  endtask

  task automatic test_pause();
    logic [7:0] s; bit e; int b;
    run(0, -1, 0, -1, 0, 0, 3, 5, s, e, b);
    run(1, -1, 0, -1, 0, 1, 3, 5, s, e, b);
    do_clear(0);
  endtask

  task automatic test_random();
    logic [7:0] s; bit e; int b;
    for (int i = 0; i < 6; i++) begin
      int k = $urandom_range(0, 2);
      run(k, $urandom_range(0, 15), 8'($urandom), $urandom_range(0, 15), 8'($urandom),
          1, $urandom_range(0, 15), $urandom_range(0, 6), s, e, b);
    end
  endtask

  task automatic test_async_reset();
    do_clear(0);
    @(negedge clk);
    en[0] = 1; vld[0] = 1; din[0] = 8'h55;
    repeat (4) @(negedge clk);
    tests++; if (er[0] !== 1'b1 || bc[0] === 16'd0) begin fails++; $display("FAIL pre_reset got err %b count %0d want 1 nonzero", er[0], bc[0]); end
    @(posedge clk);
    #2 rst = 1;
    #1;
    tests++; if ({rdy[0], dn[0], er[0]} !== 3'b000) begin fails++; $display("FAIL async_flags got %b want 000", {rdy[0], dn[0], er[0]}); end
    tests++; if ({bc[0], cs[0], bi[0], bv[0]} !== 48'd0) begin fails++; $display("FAIL async_regs got %h want 0", {bc[0], cs[0], bi[0], bv[0]}); end
    @(negedge clk);
    rst = 0; en[0] = 0; vld[0] = 0;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_backpressure();
    test_mismatch();
    test_wrap();
    test_pause();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
